// File: rtl/gain_pkg.sv
// Shared constants, types and helpers for the output gain stage.
// A gain index runs 0..720 in 0.1 dB steps, so 600 is unity (0.0 dB).
package gain_pkg;

  localparam int IDX_UNITY = 600;
  localparam int IDX_MAX   = 720;
  localparam int R_STEPS   = 60;
  localparam int Q_UNITY   = 10;
  localparam int FRAC_BITS = 14;

  typedef logic [9:0] idx_t;  // applied / target gain index, 0..720
  typedef logic [3:0] q_t;    // whole 6 dB octaves, 0..12
  typedef logic [5:0] r_t;    // 0.1 dB steps inside an octave, 0..59

  // Mantissa table in Q1.14: round(16384 * 10^(r/200)) for r = 0..59
  localparam logic [15:0] GAIN_LUT [R_STEPS] = '{
    16'd16384, 16'd16574, 16'd16766, 16'd16960, 16'd17156, 16'd17355, 16'd17556, 16'd17759, 16'd17965, 16'd18173,
    16'd18383, 16'd18596, 16'd18811, 16'd19029, 16'd19250, 16'd19472, 16'd19698, 16'd19926, 16'd20157, 16'd20390,
    16'd20626, 16'd20865, 16'd21107, 16'd21351, 16'd21598, 16'd21848, 16'd22101, 16'd22357, 16'd22616, 16'd22878,
    16'd23143, 16'd23411, 16'd23682, 16'd23956, 16'd24234, 16'd24514, 16'd24798, 16'd25085, 16'd25376, 16'd25670,
    16'd25967, 16'd26268, 16'd26572, 16'd26879, 16'd27191, 16'd27506, 16'd27824, 16'd28146, 16'd28472, 16'd28802,
    16'd29135, 16'd29473, 16'd29814, 16'd30159, 16'd30508, 16'd30862, 16'd31219, 16'd31581, 16'd31946, 16'd32316
  };

  function automatic int bcd3_to_tenths(input logic [3:0] d2, input logic [3:0] d1,
                                        input logic [3:0] d0, input logic negative);
    int v;
    v = int'(d2) * 100 + int'(d1) * 10 + int'(d0);
    return negative ? -v : v;
  endfunction

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/gain_ramp.sv
// Walks the applied gain index one 0.1 dB step toward the target every RAMP_DIV samples.
// The index is kept split as (q, r) so the datapath needs only a shift and a 60-entry table.
module gain_ramp
  import gain_pkg::*;
#(
  parameter int RAMP_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_valid,
  input  idx_t target_idx,
  output q_t   q,
  output r_t   r,
  output logic at_target
);

  localparam int CNT_W = $clog2(RAMP_DIV + 1);

  logic [CNT_W-1:0] cnt;
  idx_t             applied;
  logic             step_now;

  always_comb begin
    applied  = idx_t'(q) * idx_t'(R_STEPS) + idx_t'(r);
    step_now = sample_valid && (cnt == CNT_W'(RAMP_DIV - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; this is what lets the stepping sample use the old gain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      q         <= q_t'(Q_UNITY);
      r         <= '0;
      at_target <= 1'b1;
    end else begin
      at_target <= (applied == target_idx);
      if (sample_valid) cnt <= step_now ? '0 : cnt + CNT_W'(1);
      if (step_now && applied < target_idx) begin
        if (r == r_t'(R_STEPS - 1)) begin
          r <= '0;
          q <= q + q_t'(1);
        end else begin
          r <= r + r_t'(1);
        end
      end else if (step_now && applied > target_idx) begin
        if (r == '0) begin
          r <= r_t'(R_STEPS - 1);
          q <= q - q_t'(1);
        end else begin
          r <= r - r_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/output_gain_stage.sv
// Applies a signed BCD gain setting (0.1 dB units, -60.0..+12.0 dB) to a 16-bit stream
// through a two-stage multiply / round-shift / saturate pipeline.
module output_gain_stage
  import gain_pkg::*;
#(
  parameter int RAMP_DIV = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         num2,
  input  logic [3:0]         num1,
  input  logic [3:0]         num0,
  input  logic               neg,
  input  logic               sample_valid,
  input  logic signed [15:0] sample_in,
  output logic signed [15:0] sample_out,
  output logic               out_valid,
  output logic               at_target
);

  idx_t               target_idx;
  idx_t               target_next;
  logic               digits_ok;
  int                 biased;
  q_t                 q;
  q_t                 q1;
  r_t                 r;
  logic               v1;
  logic signed [32:0] prod;
  logic signed [32:0] p1;
  logic signed [32:0] rnd;
  logic signed [32:0] y;
  logic [4:0]         shamt;
  logic signed [15:0] sat;

  always_comb begin
    biased    = bcd3_to_tenths(num2, num1, num0, neg) + IDX_UNITY;
    digits_ok = bcd_digit_ok(num2) && bcd_digit_ok(num1) && bcd_digit_ok(num0);
    if (biased < 0)            target_next = '0;
    else if (biased > IDX_MAX) target_next = idx_t'(IDX_MAX);
    else                       target_next = idx_t'(biased);
  end

  // Malformed digits keep the last good setting rather than jumping somewhere arbitrary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       target_idx <= idx_t'(IDX_UNITY);
    else if (digits_ok) target_idx <= target_next;
  end

  gain_ramp #(.RAMP_DIV(RAMP_DIV)) u_ramp (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .target_idx   (target_idx),
    .q            (q),
    .r            (r),
    .at_target    (at_target)
  );

  // Stage 1: signed sample times unsigned Q1.14 mantissa, both widened to 33 bits
  always_comb begin
    prod = $signed({{17{sample_in[15]}}, sample_in}) * $signed({17'd0, GAIN_LUT[r]});
  end

  // Stage 2: octave count becomes a right shift of 12..24 with round-half-up
  always_comb begin
    shamt = 5'd24 - {1'b0, q1};
    rnd   = 33'sd1 <<< (shamt - 5'd1);
    y     = (p1 + rnd) >>> shamt;
    if (y > 33'sd32767)       sat = 16'sh7fff;
    else if (y < -33'sd32768) sat = 16'sh8000;
    else                      sat = y[15:0];
  end

  // NOTE: the data registers are reset too, not only the valids, so sample_out reads 0
  // after reset and no stale product can leak out of a dropped transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1         <= 1'b0;
      p1         <= '0;
      q1         <= q_t'(Q_UNITY);
      out_valid  <= 1'b0;
      sample_out <= '0;
    end else begin
      v1        <= sample_valid;
      out_valid <= v1;
      if (sample_valid) begin
        p1 <= prod;
        q1 <= q;
      end
      if (v1) sample_out <= sat;
    end
  end

endmodule

// File: tb/tb_output_gain_stage.sv
// Scoreboard bench for output_gain_stage: the driver queues hand-computed results,
// a negedge monitor pops them whenever out_valid is seen and also checks the 2-cycle latency.
module tb_output_gain_stage;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [3:0]         num2, num1, num0;
  logic               neg;
  logic               sample_valid;
  logic signed [15:0] sample_in;
  logic signed [15:0] sample_out;
  logic               out_valid;
  logic               at_target;

  typedef struct {
    int    val;
    int    stamp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  output_gain_stage #(.RAMP_DIV(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .num2         (num2),
    .num1         (num1),
    .num0         (num0),
    .neg          (neg),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .at_target    (at_target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got out_valid=1 with sample_out=%0d, expected no output", sample_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, int'(sample_out), e.val);
        check({e.name, "_latency"}, cyc - e.stamp, 2);
      end
    end
  end

  task automatic set_gain(input logic n, input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    @(negedge clk);
    sample_valid = 1'b0;
    neg = n; num2 = d2; num1 = d1; num0 = d0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  task automatic send(input int x, input int exp, input string nm);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 16'(x);
    sb.push_back('{val: exp, stamp: cyc, name: nm});
  endtask

  // n zero samples (always yield 0), confirming at_target only after the last step
  task automatic ramp(input int n, input string nm);
    for (int i = 0; i < n - 1; i++) send(0, 0, {nm, "_zero"});
    idle(3);
    check({nm, "_not_yet_at_target"}, int'(at_target), 0);
    send(0, 0, {nm, "_zero"});
    idle(3);
    check({nm, "_at_target"}, int'(at_target), 1);
  endtask

  initial begin
    reset_n = 1'b0;
    neg = 1'b0; num2 = 4'd0; num1 = 4'd0; num0 = 4'd0;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(negedge clk);
    check("reset_sample_out", int'(sample_out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_at_target", int'(at_target), 1);
    reset_n = 1'b1;
    idle(2);

    // 1: unity gain
    send(1000, 1000, "t1_unity");
    idle(3);
    check("t1_at_target", int'(at_target), 1);

    // 2: -6.0 dB, stepping down through the r wrap
    set_gain(1'b1, 4'd0, 4'd6, 4'd0);
    idle(3);
    check("t2_at_target_drop", int'(at_target), 0);
    send(1000, 1000, "t2_first");
    send(1000, 986, "t2_second");
    send(1000, 975, "t2_third");
    ramp(57, "t2");
    send(1000, 500, "t2_steady");
    send(1001, 501, "t2_round_pos");
    send(-1001, -500, "t2_round_neg");
    idle(3);

    // 3: +12.0 dB, saturation both ways
    set_gain(1'b0, 4'd1, 4'd2, 4'd0);
    idle(3);
    ramp(180, "t3");
    send(20000, 32767, "t3_sat_pos");
    send(-20000, -32768, "t3_sat_neg");
    send(1000, 4000, "t3_gain4");
    idle(3);

    // 4: clamp to idx 0, then to idx 720
    set_gain(1'b1, 4'd9, 4'd9, 4'd9);
    idle(3);
    ramp(720, "t4_min");
    send(16384, 16, "t4_min_pos");
    send(-16384, -16, "t4_min_neg");
    send(32767, 32, "t4_min_full");
    idle(3);
    set_gain(1'b0, 4'd9, 4'd9, 4'd9);
    idle(3);
    ramp(720, "t4_max");
    send(1000, 4000, "t4_max_gain4");
    send(8191, 32764, "t4_max_edge");
    send(8192, 32767, "t4_max_sat");
    idle(3);

    // 5: back to unity, then an invalid digit must hold the target
    set_gain(1'b0, 4'd0, 4'd0, 4'd0);
    idle(3);
    ramp(120, "t5_unity");
    set_gain(1'b0, 4'd0, 4'hC, 4'd0);
    idle(4);
    check("t5_bad_digit_at_target", int'(at_target), 1);
    send(1000, 1000, "t5_bad_digit_out");
    idle(3);
    check("t5_bad_digit_at_target_late", int'(at_target), 1);

    // 6: reset mid-ramp with one sample leaving and one in flight
    set_gain(1'b1, 4'd0, 4'd6, 4'd0);
    idle(3);
    for (int i = 0; i < 10; i++) send(0, 0, "t6_zero");
    idle(3);
    send(1000, 889, "t6_before_reset");
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 16'sd1000;
    @(negedge clk);
    sample_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    neg = 1'b0; num1 = 4'd0;
    #1;
    check("t6_reset_out_valid", int'(out_valid), 0);
    check("t6_reset_sample_out", int'(sample_out), 0);
    check("t6_reset_at_target", int'(at_target), 1);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    send(1000, 1000, "t6_after_reset");
    idle(5);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
